// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// Holds the opcode values decoded by the controller, the ALUOp codes handed
// to the ALU control decoder, the PCSrc / ALUSrcB mux select codes and the
// 4-bit state encoding of the control FSM.
package multicycle_control_pkg;

    // Opcodes (IR[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // Control FSM states; encodings 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback per opcode, stalls
// on a req/ready memory handshake and counts retired instructions.
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   opcode_i       IR[31:26], valid from DECODE onward
//   zero_i         ALU zero flag (branch decision)
//   memReady_i     memory completes the current request this cycle
//   memReq_o       memory request, held until memReady_i
//   memWrite_o     store qualifier for memReq_o
//   iorD_o         0 = address from PC, 1 = from ALUOut
//   irWrite_o      instruction register load
//   pcEn_o         PC write enable
//   pcSrc_o        PC source select
//   aluSrcA_o      0 = PC, 1 = regA
//   aluSrcB_o      ALU operand B select
//   aluOp_o        ALUOp code for the ALU control decoder
//   regDst_o       0 = rt, 1 = rd
//   memtoReg_o     0 = ALUOut, 1 = MDR
//   regWrite_o     register file write enable
//   illegalOp_o    one-cycle pulse on an unsupported opcode
//   instrCount_o   retired instruction count, wraps modulo 2^CNT_W
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             memReady_i,
    output logic             memReq_o,
    output logic             memWrite_o,
    output logic             iorD_o,
    output logic             irWrite_o,
    output logic             pcEn_o,
    output logic [1:0]       pcSrc_o,
    output logic             aluSrcA_o,
    output logic [1:0]       aluSrcB_o,
    output logic [1:0]       aluOp_o,
    output logic             regDst_o,
    output logic             memtoReg_o,
    output logic             regWrite_o,
    output logic             illegalOp_o,
    output logic [CNT_W-1:0] instrCount_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  instrCount_q, instrCount_d;
    logic              retire;

    // State and retired-instruction counter registers; reset returns the
    // controller to FETCH and clears the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_FETCH;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            instrCount_q <= instrCount_d;
        end
    end

    // Next-state and output decode. Outputs are Moore except PCEn/IRWrite,
    // which are qualified by memReady_i in FETCH and by zero_i in BRANCH.
    // All outputs are forced low while reset is held so an in-flight memory
    // request is dropped immediately rather than at the next clock edge.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        memReq_o    = 1'b0;
        memWrite_o  = 1'b0;
        iorD_o      = 1'b0;
        irWrite_o   = 1'b0;
        pcEn_o      = 1'b0;
        pcSrc_o     = PCSRC_ALU;
        aluSrcA_o   = 1'b0;
        aluSrcB_o   = SRCB_REGB;
        aluOp_o     = ALUOP_ADD;
        regDst_o    = 1'b0;
        memtoReg_o  = 1'b0;
        regWrite_o  = 1'b0;
        illegalOp_o = 1'b0;

        case (state_q)
            S_FETCH: begin
                memReq_o  = 1'b1;
                aluSrcB_o = SRCB_FOUR;
                irWrite_o = memReady_i;
                pcEn_o    = memReady_i;
                if (memReady_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                aluSrcB_o = SRCB_IMMSH2;
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = SRCB_IMM;
                if (opcode_i == OP_LW)      state_d = S_MEMRD;
                else if (opcode_i == OP_SW) state_d = S_MEMWR;
                else                        state_d = S_FETCH;
            end
            S_MEMRD: begin
                memReq_o = 1'b1;
                iorD_o   = 1'b1;
                if (memReady_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoReg_o = 1'b1;
                regWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memReq_o   = 1'b1;
                memWrite_o = 1'b1;
                iorD_o     = 1'b1;
                if (memReady_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                aluSrcA_o = 1'b1;
                aluOp_o   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regDst_o   = 1'b1;
                regWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA_o = 1'b1;
                aluOp_o   = ALUOP_SUB;
                pcSrc_o   = PCSRC_ALUOUT;
                pcEn_o    = zero_i;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pcSrc_o = PCSRC_JUMP;
                pcEn_o  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegalOp_o = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (!rst_ni) begin
            retire      = 1'b0;
            memReq_o    = 1'b0;
            memWrite_o  = 1'b0;
            iorD_o      = 1'b0;
            irWrite_o   = 1'b0;
            pcEn_o      = 1'b0;
            pcSrc_o     = PCSRC_ALU;
            aluSrcA_o   = 1'b0;
            aluSrcB_o   = SRCB_REGB;
            aluOp_o     = ALUOP_ADD;
            regDst_o    = 1'b0;
            memtoReg_o  = 1'b0;
            regWrite_o  = 1'b0;
            illegalOp_o = 1'b0;
        end
    end

    // Counter advances on the edge that leaves a retiring state
    always_comb begin
        instrCount_d = instrCount_q;
        if (retire) instrCount_d = instrCount_q + CNT_W'(1);
    end

    assign instrCount_o = instrCount_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard testbench for multicycle_control (CNT_W = 4).
// The stimulus process drives one cycle at a time and pushes the expected
// control vector and count for that cycle; the monitor pops and compares on
// the falling edge.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CNT_W = 4;

    // Expected control vectors, packed as
    // {memReq, memWrite, iorD, irWrite, pcEn, pcSrc[1:0], aluSrcA,
    //  aluSrcB[1:0], aluOp[1:0], regDst, memtoReg, regWrite, illegalOp}
    localparam logic [15:0] C_ZERO   = 16'b0_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] C_FETCH  = 16'b1_0_0_1_1_00_0_01_00_0_0_0_0;
    localparam logic [15:0] C_FSTALL = 16'b1_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [15:0] C_DECODE = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [15:0] C_MEMRD  = 16'b1_0_1_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_00_0_00_00_0_1_1_0;
    localparam logic [15:0] C_MEMWR  = 16'b1_1_1_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [15:0] C_ALUWB  = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [15:0] C_BRT    = 16'b0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [15:0] C_BRNT   = 16'b0_0_0_0_0_01_1_00_01_0_0_0_0;
    localparam logic [15:0] C_JUMP   = 16'b0_0_0_0_1_10_0_00_00_0_0_0_0;
    localparam logic [15:0] C_ADDIEX = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_00_0_00_00_0_0_1_0;
    localparam logic [15:0] C_TRAP   = 16'b0_0_0_0_0_00_0_00_00_0_0_0_1;
    localparam logic [5:0]  OP_BAD   = 6'b111111;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [5:0]       opcode_i = '0;
    logic             zero_i = 1'b0;
    logic             memReady_i = 1'b0;
    logic             memReq_o, memWrite_o, iorD_o, irWrite_o, pcEn_o;
    logic [1:0]       pcSrc_o, aluSrcB_o, aluOp_o;
    logic             aluSrcA_o, regDst_o, memtoReg_o, regWrite_o, illegalOp_o;
    logic [CNT_W-1:0] instrCount_o;
    logic [15:0]      actCtrl;

    typedef struct {
        logic [15:0]      ctrl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .memReady_i   (memReady_i),
        .memReq_o     (memReq_o),
        .memWrite_o   (memWrite_o),
        .iorD_o       (iorD_o),
        .irWrite_o    (irWrite_o),
        .pcEn_o       (pcEn_o),
        .pcSrc_o      (pcSrc_o),
        .aluSrcA_o    (aluSrcA_o),
        .aluSrcB_o    (aluSrcB_o),
        .aluOp_o      (aluOp_o),
        .regDst_o     (regDst_o),
        .memtoReg_o   (memtoReg_o),
        .regWrite_o   (regWrite_o),
        .illegalOp_o  (illegalOp_o),
        .instrCount_o (instrCount_o)
    );

    assign actCtrl = {memReq_o, memWrite_o, iorD_o, irWrite_o, pcEn_o, pcSrc_o,
                      aluSrcA_o, aluSrcB_o, aluOp_o, regDst_o, memtoReg_o,
                      regWrite_o, illegalOp_o};

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs shortly after the rising edge, record what
    // the DUT should show during that cycle, then advance to the next cycle.
    task automatic applyStimulus(input logic rst, input logic [5:0] op,
                                 input logic rdy, input logic z,
                                 input logic [15:0] ctrl,
                                 input logic [CNT_W-1:0] cnt,
                                 input string name);
        exp_t e;
        rst_ni     = rst;
        opcode_i   = op;
        memReady_i = rdy;
        zero_i     = z;
        e.ctrl = ctrl;
        e.cnt  = cnt;
        e.name = name;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL %s ctrl: got %b expected %b", e.name, actCtrl, e.ctrl);
        end
        checks++;
        if (instrCount_o !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d expected %0d", e.name, instrCount_o, e.cnt);
        end
    endtask

    // Monitor: compares on the falling edge whenever an expectation is queued
    initial begin
        forever begin
            @(negedge clk_i);
            if (sb.size() != 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(posedge clk_i);
        #1;
        // Reset held: all outputs low, count zero
        applyStimulus(1'b0, OP_RTYPE, 1'b1, 1'b0, C_ZERO, 4'd0, "reset0");
        applyStimulus(1'b0, OP_RTYPE, 1'b1, 1'b0, C_ZERO, 4'd0, "reset1");

        // R-type, no wait states
        applyStimulus(1'b1, OP_RTYPE, 1'b1, 1'b0, C_FETCH,  4'd0, "r.fetch");
        applyStimulus(1'b1, OP_RTYPE, 1'b1, 1'b0, C_DECODE, 4'd0, "r.decode");
        applyStimulus(1'b1, OP_RTYPE, 1'b1, 1'b0, C_EXEC,   4'd0, "r.exec");
        applyStimulus(1'b1, OP_RTYPE, 1'b1, 1'b0, C_ALUWB,  4'd0, "r.aluwb");

        // LW with two MemReady-low cycles in MEMRD
        applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, C_FETCH,  4'd1, "lw.fetch");
        applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, C_DECODE, 4'd1, "lw.decode");
        applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, C_MEMADR, 4'd1, "lw.memadr");
        applyStimulus(1'b1, OP_LW, 1'b0, 1'b0, C_MEMRD,  4'd1, "lw.memrd0");
        applyStimulus(1'b1, OP_LW, 1'b0, 1'b0, C_MEMRD,  4'd1, "lw.memrd1");
        applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, C_MEMRD,  4'd1, "lw.memrd2");
        applyStimulus(1'b1, OP_LW, 1'b1, 1'b0, C_MEMWB,  4'd1, "lw.memwb");

        // BEQ taken then not taken
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b1, C_FETCH,  4'd2, "beqT.fetch");
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b1, C_DECODE, 4'd2, "beqT.decode");
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b1, C_BRT,    4'd2, "beqT.branch");
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b0, C_FETCH,  4'd3, "beqN.fetch");
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b0, C_DECODE, 4'd3, "beqN.decode");
        applyStimulus(1'b1, OP_BEQ, 1'b1, 1'b0, C_BRNT,   4'd3, "beqN.branch");

        // Illegal opcode: one trap pulse, count unchanged
        applyStimulus(1'b1, OP_BAD, 1'b1, 1'b0, C_FETCH,  4'd4, "ill.fetch");
        applyStimulus(1'b1, OP_BAD, 1'b1, 1'b0, C_DECODE, 4'd4, "ill.decode");
        applyStimulus(1'b1, OP_BAD, 1'b1, 1'b0, C_TRAP,   4'd4, "ill.trap");

        // ADDI with one FETCH stall (also checks count after the trap)
        applyStimulus(1'b1, OP_ADDI, 1'b0, 1'b0, C_FSTALL, 4'd4, "addi.fstall");
        applyStimulus(1'b1, OP_ADDI, 1'b1, 1'b0, C_FETCH,  4'd4, "addi.fetch");
        applyStimulus(1'b1, OP_ADDI, 1'b1, 1'b0, C_DECODE, 4'd4, "addi.decode");
        applyStimulus(1'b1, OP_ADDI, 1'b1, 1'b0, C_ADDIEX, 4'd4, "addi.ex");
        applyStimulus(1'b1, OP_ADDI, 1'b1, 1'b0, C_ADDIWB, 4'd4, "addi.wb");

        // SW with one wait state
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_FETCH,  4'd5, "sw.fetch");
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_DECODE, 4'd5, "sw.decode");
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_MEMADR, 4'd5, "sw.memadr");
        applyStimulus(1'b1, OP_SW, 1'b0, 1'b0, C_MEMWR,  4'd5, "sw.memwr0");
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_MEMWR,  4'd5, "sw.memwr1");

        // SW interrupted by reset while the store request is outstanding
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_FETCH,  4'd6, "swr.fetch");
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_DECODE, 4'd6, "swr.decode");
        applyStimulus(1'b1, OP_SW, 1'b1, 1'b0, C_MEMADR, 4'd6, "swr.memadr");
        applyStimulus(1'b1, OP_SW, 1'b0, 1'b0, C_MEMWR,  4'd6, "swr.memwr");
        applyStimulus(1'b0, OP_SW, 1'b0, 1'b0, C_ZERO,   4'd0, "swr.rstnow");
        applyStimulus(1'b0, OP_SW, 1'b1, 1'b0, C_ZERO,   4'd0, "swr.rsthold");
        applyStimulus(1'b1, OP_J,  1'b0, 1'b0, C_FSTALL, 4'd0, "swr.release");

        // 16 jumps: counter wraps 15 -> 0 on a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, OP_J, 1'b1, 1'b0, C_FETCH,  CNT_W'(i), "j.fetch");
            applyStimulus(1'b1, OP_J, 1'b1, 1'b0, C_DECODE, CNT_W'(i), "j.decode");
            applyStimulus(1'b1, OP_J, 1'b1, 1'b0, C_JUMP,   CNT_W'(i), "j.jump");
        end
        applyStimulus(1'b1, OP_J, 1'b0, 1'b0, C_FSTALL, 4'd0, "j.wrapped");

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk_i);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
